// File: rtl/ip_tx_pkg.sv
// ip_tx_pkg: shared constants and state encoding
// for the IPv4 transmit header path.
package ip_tx_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  PROTO_ICMP     = 8'd1;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;
    localparam int          IP_HDR_BYTES   = 20;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } tx_state_t;

endpackage

// File: rtl/ip_hdr_csum.sv
// ip_hdr_csum: combinational IPv4 header checksum
// over the nine non-checksum header words.
module ip_hdr_csum (
    input  logic [15:0] w0,
    input  logic [15:0] w1,
    input  logic [15:0] w2,
    input  logic [15:0] w3,
    input  logic [15:0] w4,
    input  logic [15:0] w5,
    input  logic [15:0] w6,
    input  logic [15:0] w7,
    input  logic [15:0] w8,
    output logic [15:0] csum
);

    logic [19:0] acc;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // one's-complement sum, two end-around folds, then invert
    always_comb begin
        acc = 20'(w0) + 20'(w1) + 20'(w2) + 20'(w3) + 20'(w4)
            + 20'(w5) + 20'(w6) + 20'(w7) + 20'(w8);
        fold1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        csum  = ~fold2;
    end

endmodule

// File: rtl/ip_hdr_tx.sv
// ip_hdr_tx: prepends EtherType and IPv4 header to a
// payload byte stream through a header-length shift register.
module ip_hdr_tx
    import ip_tx_pkg::*;
#(
    parameter logic [7:0]  TTL          = 8'h80,
    parameter bit          DF           = 1'b1,
    parameter bit          ETHERTYPE_EN = 1'b1,
    parameter logic [15:0] ID_INIT      = 16'h0000,
    parameter bit          ID_INCR      = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_enable,
    output logic        ready,
    output logic        active,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic [7:0]  protocol,
    input  logic [5:0]  dscp,
    input  logic [15:0] length,
    input  logic [31:0] local_ip,
    input  logic [31:0] destination_ip,
    output logic [15:0] ip_id,
    output logic        len_err
);

    localparam int HDR_LEN = ETHERTYPE_EN ? IP_HDR_BYTES + 2
                                          : IP_HDR_BYTES;
    localparam int SR_W = HDR_LEN * 8;
    localparam int IP_W = IP_HDR_BYTES * 8;
    // drain_left counts bytes still to emit, the current one included
    localparam logic [4:0] DRAIN_LOAD = 5'(HDR_LEN - 1);

    tx_state_t state;
    tx_state_t state_n;

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] hdr;
    logic [IP_W-1:0] ip_hdr;
    logic [15:0]     byte_cnt;
    logic [15:0]     len_q;
    logic [4:0]      drain_left;
    logic            last;

    logic [15:0] w_ver_tos;
    logic [15:0] w_total_len;
    logic [15:0] w_flags;
    logic [15:0] w_ttl_proto;
    logic [15:0] csum;

    assign w_ver_tos   = {IP_VER_IHL, dscp, 2'b00};
    assign w_total_len = 16'(IP_HDR_BYTES) + length;
    assign w_flags     = DF ? 16'h4000 : 16'h0000;
    assign w_ttl_proto = {TTL, protocol};

    ip_hdr_csum u_csum (
        .w0   (w_ver_tos),
        .w1   (w_total_len),
        .w2   (ip_id),
        .w3   (w_flags),
        .w4   (w_ttl_proto),
        .w5   (local_ip[31:16]),
        .w6   (local_ip[15:0]),
        .w7   (destination_ip[31:16]),
        .w8   (destination_ip[15:0]),
        .csum (csum)
    );

    assign ip_hdr = {w_ver_tos, w_total_len, ip_id, w_flags,
                     w_ttl_proto, csum, local_ip, destination_ip};

    generate
        if (ETHERTYPE_EN) begin : g_eth
            assign hdr = {ETHERTYPE_IPV4, ip_hdr};
        end else begin : g_noeth
            assign hdr = ip_hdr;
        end
    endgenerate

    assign data_out = sr[SR_W-1 -: 8];
    assign ready    = (state == IDLE);
    assign active   = tx_enable | (state != IDLE);
    assign len_err  = last & (byte_cnt != len_q);

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next state and end-of-drain detect
    always_comb begin
        state_n = state;
        last    = 1'b0;
        unique case (state)
            IDLE:    if (tx_enable) state_n = STREAM;
            STREAM:  if (!tx_enable) state_n = DRAIN;
            DRAIN: begin
                last = (drain_left == 5'd1);
                if (last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // header load, byte shifting, counters and packet id
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            byte_cnt   <= '0;
            len_q      <= '0;
            drain_left <= '0;
            ip_id      <= ID_INIT;
        end else begin
            unique case (state)
                IDLE: begin
                    len_q <= length;
                    if (tx_enable) begin
                        sr       <= {sr[SR_W-9:0], data_in};
                        byte_cnt <= 16'd1;
                    end else begin
                        sr       <= hdr;
                        byte_cnt <= '0;
                    end
                end
                STREAM: begin
                    if (tx_enable) begin
                        sr <= {sr[SR_W-9:0], data_in};
                        if (byte_cnt != 16'hFFFF)
                            byte_cnt <= byte_cnt + 16'd1;
                    end else begin
                        sr         <= {sr[SR_W-9:0], 8'h00};
                        drain_left <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    sr         <= {sr[SR_W-9:0], 8'h00};
                    drain_left <= drain_left - 5'd1;
                    if (last && ID_INCR)
                        ip_id <= ip_id + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_hdr_tx.sv
// tb_ip_hdr_tx: three parameterisations of ip_hdr_tx checked
// against a byte-level model of the IPv4 header stream.
module tb_ip_hdr_tx;
    import ip_tx_pkg::*;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          n;
        logic [15:0] len;
        logic [7:0]  proto;
        logic [5:0]  ds;
        logic [31:0] lip;
        logic [31:0] dip;
        bit          poke;
        logic [15:0] e_tlen;
        logic [15:0] e_csum;
        bit          e_csum_v;
        bit          e_err;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        tx_enable;
    logic [7:0]  data_in;
    logic [7:0]  protocol;
    logic [5:0]  dscp;
    logic [15:0] length;
    logic [31:0] local_ip;
    logic [31:0] destination_ip;

    logic [2:0]  rdy;
    logic [2:0]  act;
    logic [2:0]  err;
    logic [7:0]  dout [3];
    logic [15:0] idv  [3];

    bit          p_eth  [3] = '{1'b1, 1'b1, 1'b0};
    bit          p_df   [3] = '{1'b1, 1'b1, 1'b0};
    bit          p_incr [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  p_ttl  [3] = '{8'h80, 8'h80, 8'h40};
    logic [15:0] p_init [3] = '{16'h0000, 16'hFFFF, 16'h1234};
    int          p_hl   [3] = '{22, 22, 20};
    logic [15:0] mid    [3];

    bq_t cap [3];
    int  tests = 0;
    int  fails = 0;

    always #5 clock = ~clock;

    ip_hdr_tx #(
        .TTL(8'h80), .DF(1'b1), .ETHERTYPE_EN(1'b1),
        .ID_INIT(16'h0000), .ID_INCR(1'b1)
    ) dut_a (
        .clock(clock), .reset(reset), .tx_enable(tx_enable),
        .ready(rdy[0]), .active(act[0]), .data_in(data_in),
        .data_out(dout[0]), .protocol(protocol), .dscp(dscp),
        .length(length), .local_ip(local_ip),
        .destination_ip(destination_ip), .ip_id(idv[0]),
        .len_err(err[0])
    );

    ip_hdr_tx #(
        .TTL(8'h80), .DF(1'b1), .ETHERTYPE_EN(1'b1),
        .ID_INIT(16'hFFFF), .ID_INCR(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .tx_enable(tx_enable),
        .ready(rdy[1]), .active(act[1]), .data_in(data_in),
        .data_out(dout[1]), .protocol(protocol), .dscp(dscp),
        .length(length), .local_ip(local_ip),
        .destination_ip(destination_ip), .ip_id(idv[1]),
        .len_err(err[1])
    );

    ip_hdr_tx #(
        .TTL(8'h40), .DF(1'b0), .ETHERTYPE_EN(1'b0),
        .ID_INIT(16'h1234), .ID_INCR(1'b0)
    ) dut_c (
        .clock(clock), .reset(reset), .tx_enable(tx_enable),
        .ready(rdy[2]), .active(act[2]), .data_in(data_in),
        .data_out(dout[2]), .protocol(protocol), .dscp(dscp),
        .length(length), .local_ip(local_ip),
        .destination_ip(destination_ip), .ip_id(idv[2]),
        .len_err(err[2])
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_stream(input string nm, input bq_t got,
                              input bq_t want);
        int bad;
        bad = -1;
        for (int i = 0; i < want.size() && bad < 0; i++)
            if (i >= got.size() || got[i] !== want[i]) bad = i;
        if (bad < 0 && got.size() != want.size()) bad = want.size();
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s size %0d want %0d first bad byte %0d got %h want %h",
                     nm, got.size(), want.size(), bad,
                     (bad < got.size()) ? got[bad] : 8'hxx,
                     (bad < want.size()) ? want[bad] : 8'hxx);
        end
    endtask

    // header as the byte sequence the IPv4 rules describe
    function automatic bq_t model_hdr(
        input bit eth, input logic [7:0] ttl, input bit df,
        input logic [15:0] id, input logic [15:0] len,
        input logic [7:0] proto, input logic [5:0] ds,
        input logic [31:0] lip, input logic [31:0] dip);
        int unsigned w [9];
        int unsigned s;
        bq_t q;
        w[0] = 32'h4500 + (32'(ds) << 2);
        w[1] = (32'd20 + 32'(len)) % 32'd65536;
        w[2] = 32'(id);
        w[3] = df ? 32'h4000 : 32'h0;
        w[4] = 32'(ttl) * 256 + 32'(proto);
        w[5] = lip >> 16;
        w[6] = lip & 32'hFFFF;
        w[7] = dip >> 16;
        w[8] = dip & 32'hFFFF;
        s = 0;
        for (int i = 0; i < 9; i++) s += w[i];
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        s = ~s & 32'hFFFF;
        q = {};
        if (eth) begin
            q.push_back(8'h08);
            q.push_back(8'h00);
        end
        for (int i = 0; i < 5; i++) begin
            q.push_back(8'(w[i] >> 8));
            q.push_back(8'(w[i]));
        end
        q.push_back(8'(s >> 8));
        q.push_back(8'(s));
        for (int i = 5; i < 9; i++) begin
            q.push_back(8'(w[i] >> 8));
            q.push_back(8'(w[i]));
        end
        return q;
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (rdy != 3'b111 && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout got %b want 111", rdy);
        end
    endtask

    task automatic run_pkt(
        input int n, input logic [15:0] len, input logic [7:0] proto,
        input logic [5:0] ds, input logic [31:0] lip,
        input logic [31:0] dip, input bit poke, input bit seq);
        bq_t pl;
        bq_t ex [3];
        int  actn [3];
        int  errn [3];
        int  errk [3];
        int  lastk [3];
        bit  done;
        wait_ready();
        @(posedge clock); #1;
        tx_enable      = 1'b0;
        protocol       = proto;
        dscp           = ds;
        length         = len;
        local_ip       = lip;
        destination_ip = dip;
        pl = {};
        for (int i = 0; i < n; i++)
            pl.push_back(seq ? 8'(i + 1) : 8'($urandom));
        for (int d = 0; d < 3; d++) begin
            ex[d] = model_hdr(p_eth[d], p_ttl[d], p_df[d], mid[d],
                              len, proto, ds, lip, dip);
            foreach (pl[i]) ex[d].push_back(pl[i]);
            cap[d]   = {};
            actn[d]  = 0;
            errn[d]  = 0;
            errk[d]  = -1;
            lastk[d] = -1;
        end
        done = 1'b0;
        for (int k = 0; k < n + 40 && !done; k++) begin
            @(posedge clock); #1;
            tx_enable = (k < n) || (poke && k >= n + 2 && k < n + 10);
            if (k < n) data_in = pl[k];
            else       data_in = 8'($urandom);
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                if (act[d]) begin
                    cap[d].push_back(dout[d]);
                    actn[d]++;
                    lastk[d] = k;
                end
                if (err[d]) begin
                    errn[d]++;
                    errk[d] = k;
                end
            end
            if (k == n) chk("ready_low_in_stream", {29'd0, rdy}, 32'd0);
            if (k > n && act == 3'b000) begin
                done = 1'b1;
                chk("ready_after_pkt", {29'd0, rdy}, 32'd7);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL pkt_timeout active %b", act);
        end
        for (int d = 0; d < 3; d++) begin
            chk_stream($sformatf("stream_%0d", d), cap[d], ex[d]);
            chk($sformatf("active_len_%0d", d), actn[d], n + p_hl[d]);
            chk($sformatf("len_err_cnt_%0d", d), errn[d],
                (32'(n) != 32'(len)) ? 32'd1 : 32'd0);
            if (errn[d] > 0)
                chk($sformatf("len_err_when_%0d", d), errk[d], lastk[d]);
            if (p_incr[d]) mid[d] = mid[d] + 16'd1;
            chk($sformatf("ip_id_%0d", d), idv[d], mid[d]);
        end
    endtask

    vec_t vt [5];
    bq_t  golden;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8, 16'd8, PROTO_UDP, 6'd0, 32'hC0A8010A, 32'hC0A80164,
                  1'b0, 16'h001C, 16'h7712, 1'b1, 1'b0};
        vt[1] = '{8, 16'd8, PROTO_UDP, 6'd0, 32'hC0A8010A, 32'hC0A80164,
                  1'b0, 16'h001C, 16'h7711, 1'b1, 1'b0};
        vt[2] = '{4, 16'hFFF0, PROTO_UDP, 6'd0, 32'hC0A8010A,
                  32'hC0A80164, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1};
        vt[3] = '{6, 16'd8, PROTO_UDP, 6'd0, 32'hC0A8010A, 32'hC0A80164,
                  1'b1, 16'h001C, 16'h0000, 1'b0, 1'b1};
        vt[4] = '{10, 16'd10, PROTO_ICMP, 6'h2E, 32'h0A000001,
                  32'h0A000002, 1'b0, 16'h001E, 16'h0000, 1'b0, 1'b0};
        golden = '{8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00,
                   8'h40, 8'h00, 8'h80, 8'h11, 8'h77, 8'h12, 8'hC0, 8'hA8,
                   8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h64, 8'h01, 8'h02,
                   8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int d = 0; d < 3; d++) mid[d] = p_init[d];

        reset = 1'b1;
        tx_enable = 1'b0;
        data_in = 8'h00;
        protocol = 8'h00;
        dscp = 6'd0;
        length = 16'd0;
        local_ip = 32'd0;
        destination_ip = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ready_%0d", d), rdy[d], 1);
            chk($sformatf("rst_active_%0d", d), act[d], 0);
            chk($sformatf("rst_dout_%0d", d), dout[d], 0);
            chk($sformatf("rst_err_%0d", d), err[d], 0);
            chk($sformatf("rst_id_%0d", d), idv[d], p_init[d]);
        end
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_pkt(vt[i].n, vt[i].len, vt[i].proto, vt[i].ds, vt[i].lip,
                    vt[i].dip, vt[i].poke, 1'b1);
            if (cap[0].size() >= 14) begin
                chk($sformatf("vec%0d_tlen", i), {cap[0][4], cap[0][5]},
                    vt[i].e_tlen);
                if (vt[i].e_csum_v)
                    chk($sformatf("vec%0d_csum", i),
                        {cap[0][12], cap[0][13]}, vt[i].e_csum);
            end else begin
                chk($sformatf("vec%0d_size", i), cap[0].size(), 22);
            end
            if (i == 0) begin
                chk_stream("vec0_golden", cap[0], golden);
                if (cap[1].size() >= 8)
                    chk("b_first_id", {cap[1][6], cap[1][7]}, 16'hFFFF);
                chk("b_id_wrapped", idv[1], 16'h0000);
            end
            if (i == 4 && cap[2].size() > 0)
                chk("c_first_byte", cap[2][0], 8'h45);
        end

        for (int r = 0; r < 15; r++) begin
            int          n;
            logic [15:0] len;
            n = $urandom_range(1, 40);
            len = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(n);
            run_pkt(n, len, 8'($urandom), 6'($urandom), $urandom,
                    $urandom, 1'($urandom), 1'b0);
        end

        wait_ready();
        @(posedge clock); #1;
        length = 16'd20;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            tx_enable = 1'b1;
            data_in = 8'(k + 1);
        end
        #2;
        reset = 1'b1;
        tx_enable = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("arst_ready_%0d", d), rdy[d], 1);
            chk($sformatf("arst_active_%0d", d), act[d], 0);
            chk($sformatf("arst_dout_%0d", d), dout[d], 0);
            chk($sformatf("arst_err_%0d", d), err[d], 0);
            chk($sformatf("arst_id_%0d", d), idv[d], p_init[d]);
        end
        @(posedge clock); #1;
        chk("arst_err_hold", {29'd0, err}, 0);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) mid[d] = p_init[d];
        run_pkt(5, 16'd5, PROTO_UDP, 6'd3, 32'hC0A8010A, 32'hC0A80164,
                1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
